sifh_ram_arbiter: RTL and testbench

Shares one dual-port single-photon histogram RAM among `NPIX` pixel front-ends. Each pixel presents timestamp events through a req/ack handshake. The block converts every granted event into a read-modify-write increment of that pixel's time bin, with same-address forwarding and saturating counts. It also sequences the RAM zero-clear after reset and on request. It sits between the per-pixel TDC front-ends and the histogram RAM used by the peak-search FSM.

---
 rtl/sifh_pkg.sv | 22 ++
 rtl/sifh_rr_arbiter.sv | 49 ++++
 rtl/sifh_ram_arbiter.sv | 131 +++++++++++++
 tb/tb_sifh_ram_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sifh_pkg.sv
// Shared types, sizing and helpers for the single-photon histogram RAM arbiter.
package sifh_pkg;

    localparam int NPIX = 4;
    localparam int NP   = 10;
    localparam int NB   = 6;
    localparam int CW   = 8;
    localparam int PW   = $clog2(NPIX);
    localparam int AW   = PW + NB;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        CLEAR
    } state_e;

    // Time bin is the top NB bits of the timestamp.
    function automatic logic [NB-1:0] ts_bin(input logic [NP-1:0] ts);
        return ts[NP-1 -: NB];
    endfunction

endpackage

// File: rtl/sifh_rr_arbiter.sv
// Round-robin arbiter: masked requests, search starts one past the last grant.
module sifh_rr_arbiter
    import sifh_pkg::*;
(
    input  logic            clk,
    input  logic            res,
    input  logic            en_i,
    input  logic [NPIX-1:0] req_i,
    input  logic [NPIX-1:0] mask_i,
    output logic [NPIX-1:0] gnt_o,
    output logic [PW-1:0]   idx_o
);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   cand;
    logic [NPIX-1:0] elig;
    logic            found;

    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    always_comb begin
        elig  = req_i & ~mask_i;
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        ptr_d = ptr_q;
        for (int k = 0; k < NPIX; k++) begin
            cand = ptr_q + PW'(k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        if (en_i && found) begin
            gnt_o[idx_o] = 1'b1;
            ptr_d        = idx_o + PW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sifh_ram_arbiter.sv
// Grants pixel timestamp events onto a dual-port histogram RAM as saturating
// read-modify-write increments, and sequences the RAM zero-clear.
module sifh_ram_arbiter
    import sifh_pkg::*;
(
    input  logic                 clk,
    input  logic                 res,
    input  logic [NPIX-1:0]      req,
    input  logic [NPIX*NP-1:0]   ts,
    output logic [NPIX-1:0]      ack,
    input  logic                 clr_req,
    output logic                 busy,
    output logic                 sat,
    output logic [AW-1:0]        raddr,
    output logic                 rEnable,
    input  logic [CW-1:0]        counts,
    output logic [AW-1:0]        waddr,
    output logic                 wEnable,
    output logic [CW-1:0]        newCounts
);

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            clr_we_q;
    logic [NPIX-1:0] ack_q;
    logic            rd_en_q;
    logic [AW-1:0]   raddr_q;
    logic            s1_valid_q;
    logic [AW-1:0]   s1_addr_q;
    logic            fwd_valid_q;
    logic [AW-1:0]   fwd_addr_q;
    logic [CW-1:0]   fwd_data_q;
    logic            sat_q, sat_d;

    logic            grant_en;
    logic [NPIX-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic [NP-1:0]   gnt_ts;
    logic [AW-1:0]   gnt_addr;
    logic [CW-1:0]   base;
    logic [CW-1:0]   inc;
    logic            at_max;

    // Pixels acked this cycle are masked so a requester has time to update req/ts.
    assign grant_en = (state_q == RUN) && !clr_req;

    sifh_rr_arbiter u_arb (
        .clk    (clk),
        .res    (res),
        .en_i   (grant_en),
        .req_i  (req),
        .mask_i (ack_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    always_comb begin
        gnt_ts = '0;
        for (int k = 0; k < NPIX; k++) begin
            if (gnt_idx == PW'(k)) gnt_ts = ts[k*NP +: NP];
        end
    end

    assign gnt_addr = {gnt_idx, ts_bin(gnt_ts)};

    // The RAM returns old data on a same-address read-during-write; the
    // one-cycle forward register supplies the value just written instead.
    assign base   = (fwd_valid_q && (fwd_addr_q == s1_addr_q)) ? fwd_data_q : counts;
    assign at_max = (base == '1);
    assign inc    = at_max ? base : base + CW'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (clr_req) state_d = DRAIN;
            DRAIN:   state_d = CLEAR;
            CLEAR:   if (clr_we_q && (clr_cnt_q == '1)) state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        clr_cnt_d = clr_we_q ? clr_cnt_q + AW'(1) : '0;
        sat_d     = sat_q;
        if (s1_valid_q && at_max) sat_d = 1'b1;
        if ((state_d == CLEAR) && (state_q != CLEAR)) sat_d = 1'b0;
    end

    // NOTE: the histogram RAM itself is never reset; the clear sweep zeroes it.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            clr_we_q    <= 1'b0;
            ack_q       <= '0;
            rd_en_q     <= 1'b0;
            raddr_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_we_q    <= (state_d == CLEAR);
            ack_q       <= gnt;
            rd_en_q     <= |gnt;
            if (|gnt) raddr_q <= gnt_addr;
            s1_valid_q  <= rd_en_q;
            s1_addr_q   <= raddr_q;
            fwd_valid_q <= s1_valid_q;
            fwd_addr_q  <= s1_addr_q;
            fwd_data_q  <= inc;
            sat_q       <= sat_d;
        end
    end

    // Clear writes and increment writes never overlap.
    assign wEnable   = clr_we_q | s1_valid_q;
    assign waddr     = s1_valid_q ? s1_addr_q : clr_cnt_q;
    assign newCounts = s1_valid_q ? inc : '0;

    assign ack     = ack_q;
    assign rEnable = rd_en_q;
    assign raddr   = raddr_q;
    assign busy    = (state_q != RUN);
    assign sat     = sat_q;

endmodule

// File: tb/tb_sifh_ram_arbiter.sv
// Bench for sifh_ram_arbiter: behavioural RAM, per-pixel event queues and a
// histogram model that predicts every granted increment.
module tb_sifh_ram_arbiter;
    import sifh_pkg::*;

    localparam int NADDR = 1 << AW;
    localparam int MAXC  = (1 << CW) - 1;

    logic               clk = 1'b0;
    logic               res = 1'b0;
    logic [NPIX-1:0]    req = '0;
    logic [NPIX*NP-1:0] ts = '0;
    logic [NPIX-1:0]    ack;
    logic               clr_req = 1'b0;
    logic               busy;
    logic               sat;
    logic [AW-1:0]      raddr;
    logic               rEnable;
    logic [CW-1:0]      counts = '0;
    logic [AW-1:0]      waddr;
    logic               wEnable;
    logic [CW-1:0]      newCounts;

    int checks = 0;
    int failures = 0;

    logic [CW-1:0] mem [NADDR];
    int            hist [NADDR];
    logic [NP-1:0] pq [NPIX][$];
    int            exp_addr_q [$];
    int            exp_val_q [$];
    int            last_gnt = NPIX - 1;

    int            mon_g, mon_n, mon_a, mon_v;
    logic [NP-1:0] mon_ts;

    sifh_ram_arbiter dut (
        .clk       (clk),
        .res       (res),
        .req       (req),
        .ts        (ts),
        .ack       (ack),
        .clr_req   (clr_req),
        .busy      (busy),
        .sat       (sat),
        .raddr     (raddr),
        .rEnable   (rEnable),
        .counts    (counts),
        .waddr     (waddr),
        .wEnable   (wEnable),
        .newCounts (newCounts)
    );

    always #5 clk = ~clk;

    // Dual-port RAM: read-during-write on the same address returns old data.
    always @(posedge clk) begin
        if (rEnable) counts <= mem[raddr];
        if (wEnable) mem[waddr] <= newCounts;
    end

    // Monitor, scoreboard and requester model, all on the falling edge.
    always @(negedge clk) begin
        if (res) begin
            if (ack !== '0) begin
                mon_g = -1;
                mon_n = 0;
                for (int i = 0; i < NPIX; i++) if (ack[i]) begin mon_g = i; mon_n++; end
                checks++;
                if (mon_n != 1 || pq[mon_g].size() == 0) begin
                    failures++;
                    $display("FAIL ack_onehot ack=%b required one-hot on a pending pixel", ack);
                end else begin
                    mon_ts = pq[mon_g].pop_front();
                    mon_a  = mon_g * (1 << NB) + int'(mon_ts >> (NP - NB));
                    hist[mon_a] = (hist[mon_a] >= MAXC) ? MAXC : hist[mon_a] + 1;
                    exp_addr_q.push_back(mon_a);
                    exp_val_q.push_back(hist[mon_a]);
                    last_gnt = mon_g;
                    checks++;
                    if (rEnable !== 1'b1 || raddr !== AW'(mon_a)) begin
                        failures++;
                        $display("FAIL rd_addr rEnable=%b raddr=%0d required rEnable=1 raddr=%0d",
                                 rEnable, raddr, mon_a);
                    end
                end
            end
            if (wEnable === 1'b1) begin
                if (exp_addr_q.size() > 0) begin
                    mon_a = exp_addr_q.pop_front();
                    mon_v = exp_val_q.pop_front();
                    checks++;
                    if (waddr !== AW'(mon_a) || newCounts !== CW'(mon_v)) begin
                        failures++;
                        $display("FAIL wr_data waddr=%0d newCounts=%0d required waddr=%0d newCounts=%0d",
                                 waddr, newCounts, mon_a, mon_v);
                    end
                end else if (!busy) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_write waddr=%0d required no write", waddr);
                end
            end
        end
        for (int i = 0; i < NPIX; i++) begin
            req[i]          = (pq[i].size() > 0);
            ts[i*NP +: NP]  = (pq[i].size() > 0) ? pq[i][0] : '0;
        end
    end

    function automatic bit any_pending();
        for (int i = 0; i < NPIX; i++) if (pq[i].size() > 0) return 1'b1;
        return (exp_addr_q.size() > 0);
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((any_pending() || rEnable || wEnable) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (n >= 4000) begin
            failures++;
            $display("FAIL %s_timeout cycles=%0d required idle", name, n);
        end
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (ack === '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL %s_no_ack cycles=%0d required a grant", name, n);
        end
    endtask

    task automatic test_reset();
        int n;
        int bad;
        for (int a = 0; a < NADDR; a++) mem[a] = 8'hA5;
        res = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, rEnable, wEnable, sat, busy} !== 8'b0000_0001) begin
            failures++;
            $display("FAIL reset_ctrl ack=%b rEnable=%b wEnable=%b sat=%b busy=%b required 0/0/0/0/1",
                     ack, rEnable, wEnable, sat, busy);
        end
        checks++;
        if (raddr !== '0 || waddr !== '0 || newCounts !== '0) begin
            failures++;
            $display("FAIL reset_addr raddr=%0d waddr=%0d newCounts=%0d required 0",
                     raddr, waddr, newCounts);
        end
        res = 1'b1;
        n = 0;
        while (wEnable !== 1'b1 && n < 4) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL reset_busy_pre busy=%b required 1", busy);
            end
            n++;
        end
        for (int i = 0; i < NADDR; i++) begin
            checks++;
            if ({wEnable, busy, ack, waddr, newCounts} !== {1'b1, 1'b1, 4'b0, AW'(i), CW'(0)}) begin
                failures++;
                $display("FAIL reset_sweep wEnable=%b busy=%b ack=%b waddr=%0d newCounts=%0d required 1/1/0000/%0d/0",
                         wEnable, busy, ack, waddr, newCounts, i);
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || wEnable !== 1'b0) begin
            failures++;
            $display("FAIL reset_done busy=%b wEnable=%b required 0/0", busy, wEnable);
        end
        bad = 0;
        for (int a = 0; a < NADDR; a++) if (mem[a] !== '0) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_mem nonzero=%0d required 0", bad);
        end
    endtask

    task automatic test_single();
        pq[2].push_back(10'd640);
        wait_ack("single");
        checks++;
        if (ack !== 4'b0100 || rEnable !== 1'b1 || raddr !== AW'(168)) begin
            failures++;
            $display("FAIL single_read ack=%b rEnable=%b raddr=%0d required 0100/1/168", ack, rEnable, raddr);
        end
        @(negedge clk);
        checks++;
        if (wEnable !== 1'b1 || waddr !== AW'(168) || newCounts !== CW'(1)) begin
            failures++;
            $display("FAIL single_write wEnable=%b waddr=%0d newCounts=%0d required 1/168/1",
                     wEnable, waddr, newCounts);
        end
        wait_idle("single");
        checks++;
        if (mem[168] !== CW'(1)) begin
            failures++;
            $display("FAIL single_mem mem=%0d required 1", mem[168]);
        end
    endtask

    task automatic test_forwarding();
        pq[0].push_back(10'd0);
        pq[1].push_back(10'd0);
        pq[1].push_back(10'd0);
        wait_idle("fwd_alt");
        pq[0].push_back(10'd0);
        pq[0].push_back(10'd15);
        wait_idle("fwd_pair");
        checks++;
        if (mem[0] !== CW'(3) || mem[64] !== CW'(2)) begin
            failures++;
            $display("FAIL fwd_mem mem0=%0d mem64=%0d required 3/2", mem[0], mem[64]);
        end
    endtask

    task automatic test_round_robin();
        int start;
        start = (last_gnt + 1) % NPIX;
        for (int i = 0; i < NPIX; i++)
            for (int e = 0; e < 3; e++) pq[i].push_back(NP'($urandom_range(0, 511)));
        wait_ack("rr");
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (ack !== NPIX'(1 << ((start + k) % NPIX))) begin
                failures++;
                $display("FAIL rr_order step=%0d ack=%b required %b", k, ack,
                         NPIX'(1 << ((start + k) % NPIX)));
            end
            @(negedge clk);
        end
        wait_idle("rr");
    endtask

    task automatic test_saturation();
        int n_wr;
        int cyc;
        int a;
        a = 3 * (1 << NB) + 63;
        for (int e = 0; e < 260; e++) pq[3].push_back(NP'((63 << (NP - NB)) | $urandom_range(0, 15)));
        n_wr = 0;
        cyc = 0;
        while (n_wr < 260 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (wEnable === 1'b1 && waddr === AW'(a) && busy === 1'b0) begin
                n_wr++;
                checks++;
                if (sat !== (n_wr > 256)) begin
                    failures++;
                    $display("FAIL sat_timing event=%0d sat=%b required %b", n_wr, sat, (n_wr > 256));
                end
            end
        end
        checks++;
        if (n_wr != 260) begin
            failures++;
            $display("FAIL sat_events writes=%0d required 260", n_wr);
        end
        wait_idle("sat");
        checks++;
        if (mem[a] !== CW'(MAXC) || sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_final mem=%0d sat=%b required %0d/1", mem[a], sat, MAXC);
        end
    endtask

    task automatic test_clear_mid_run();
        int bad;
        for (int i = 0; i < NPIX; i++)
            for (int e = 0; e < 6; e++) pq[i].push_back(NP'($urandom_range(0, (1 << NP) - 1)));
        wait_ack("clr_stream");
        repeat (3) @(negedge clk);
        wait_ack("clr_inflight");
        clr_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, ack, rEnable, wEnable, sat} !== {1'b1, 4'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL clr_drain busy=%b ack=%b rEnable=%b wEnable=%b sat=%b required 1/0000/0/1/1",
                     busy, ack, rEnable, wEnable, sat);
        end
        @(negedge clk);
        checks++;
        if (sat !== 1'b0) begin
            failures++;
            $display("FAIL clr_sat sat=%b required 0", sat);
        end
        for (int i = 0; i < NADDR; i++) begin
            if (i == 3) clr_req = 1'b0;
            checks++;
            if ({wEnable, busy, ack, waddr, newCounts} !== {1'b1, 1'b1, 4'b0, AW'(i), CW'(0)}) begin
                failures++;
                $display("FAIL clr_sweep wEnable=%b busy=%b ack=%b waddr=%0d newCounts=%0d required 1/1/0000/%0d/0",
                         wEnable, busy, ack, waddr, newCounts, i);
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_done busy=%b required 0", busy);
        end
        for (int a = 0; a < NADDR; a++) hist[a] = 0;
        bad = 0;
        for (int a = 0; a < NADDR; a++) if (mem[a] !== '0) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL clr_mem nonzero=%0d required 0", bad);
        end
        wait_idle("clr_resume");
        bad = 0;
        for (int a = 0; a < NADDR; a++) if (mem[a] !== CW'(hist[a])) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hist_final mismatched_bins=%0d required 0", bad);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time=%0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_forwarding();
        test_round_robin();
        test_saturation();
        test_clear_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
